// File: rtl/indication_pkg.sv
// Shared definitions for the indication input demux: message field offsets,
// channel-index sizing and the tag-to-channel decode.
package indication_pkg;

  localparam int TAG_LO   = 0;
  localparam int MAX_CH_W = 4;

  typedef struct packed {
    logic                valid;
    logic [MAX_CH_W-1:0] ch;
  } tag_dec_t;

  // The message packs tag in the low bits, then meth, then v on top.
  function automatic int meth_lo(input int tag_w);
    return TAG_LO + tag_w;
  endfunction

  function automatic int v_lo(input int tag_w, input int data_w);
    return TAG_LO + tag_w + data_w;
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic tag_dec_t tag_to_ch(input logic [63:0] tag,
                                         input logic [63:0] base,
                                         input int          num_ch);
    tag_dec_t    r;
    logic [63:0] diff;
    diff    = tag - base;
    r.valid = (tag >= base) && (diff < 64'(num_ch));
    r.ch    = diff[MAX_CH_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/indication_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; head shown combinationally (zero when empty).
// Enqueue ignored when full, dequeue ignored when empty; no bypass from write to read.
module indication_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enq_i,
  input  logic [W-1:0]           enq_dat_i,
  input  logic                   deq_i,
  output logic [W-1:0]           deq_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_enq, do_deq;

  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o   = (wr_q == rd_q);
  assign count_o   = wr_q - rd_q;
  assign do_enq    = enq_i && !full_o;
  assign do_deq    = deq_i && !empty_o;
  assign deq_dat_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_enq) wr_d = wr_q + (AW+1)'(1);
    if (do_deq) rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (do_enq) mem_q[wr_q[AW-1:0]] <= enq_dat_i;
    end
  end

endmodule

// File: rtl/indication_input_demux.sv
// Buffers tagged portal messages and dispatches them in order, one-hot, to NUM_CH channels.
// One cycle enqueue-to-present; pipe stalls only when full; unknown tags are dropped and counted.
module indication_input_demux
  import indication_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          TAG_W    = 32,
  parameter int          NUM_CH   = 4,
  parameter int unsigned TAG_BASE = 1,
  parameter int          DEPTH    = 4,
  parameter int          CNT_W    = 16
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      pipe_enq_vld,
  input  logic [TAG_W+2*DATA_W-1:0] pipe_enq_dat,
  output logic                      pipe_enq_rdy,
  output logic [NUM_CH-1:0]         indication_heard_vld,
  output logic [DATA_W-1:0]         indication_heard_meth,
  output logic [DATA_W-1:0]         indication_heard_v,
  input  logic [NUM_CH-1:0]         indication_heard_rdy,
  output logic [CNT_W-1:0]          drop_count,
  output logic [$clog2(DEPTH):0]    occupancy
);
  localparam int CH_W    = ch_w(NUM_CH);
  localparam int METH_LO = meth_lo(TAG_W);
  localparam int V_LO    = v_lo(TAG_W, DATA_W);
  localparam int EW      = CH_W + 2*DATA_W;

  logic [TAG_W-1:0]  tag;
  logic [DATA_W-1:0] meth, v;
  tag_dec_t          dec;
  logic              unused_dec_ch;
  logic              enq_fire, store, drop, deq, full, empty;
  logic [EW-1:0]     head;
  logic [CH_W-1:0]   head_ch;
  logic              rdy_en_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign tag  = pipe_enq_dat[TAG_LO +: TAG_W];
  assign meth = pipe_enq_dat[METH_LO +: DATA_W];
  assign v    = pipe_enq_dat[V_LO +: DATA_W];
  assign dec  = tag_to_ch(64'(tag), 64'(TAG_BASE), NUM_CH);
  assign unused_dec_ch = ^dec.ch;

  // Ready is held low through reset and the first edge after release.
  assign pipe_enq_rdy = rdy_en_q & ~full;
  assign enq_fire     = pipe_enq_vld & pipe_enq_rdy;
  assign store        = enq_fire & dec.valid;
  assign drop         = enq_fire & ~dec.valid;

  indication_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_ni    (nRST),
    .enq_i     (store),
    .enq_dat_i ({dec.ch[CH_W-1:0], meth, v}),
    .deq_i     (deq),
    .deq_dat_o (head),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (occupancy)
  );

  assign head_ch               = head[EW-1 -: CH_W];
  assign indication_heard_meth = head[DATA_W +: DATA_W];
  assign indication_heard_v    = head[0 +: DATA_W];

  always_comb begin
    indication_heard_vld = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      indication_heard_vld[i] = !empty && (head_ch == CH_W'(i));
    end
  end

  assign deq = |(indication_heard_vld & indication_heard_rdy);

  always_comb begin
    cnt_d = cnt_q;
    if (drop && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rdy_en_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      cnt_q    <= cnt_d;
    end
  end

  assign drop_count = cnt_q;

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (nRST && drop) $display("indication_input_demux: dropped message, tag 0x%0h", tag);
  end
`endif

endmodule

// File: tb/tb_indication_input_demux.sv
// Directed and randomized bench for indication_input_demux against a queue-based reference model.
module tb_indication_input_demux;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        enq_ena, enq_ena2;
  logic [95:0] enq_v, enq_v2;
  logic        rdy, rdy2;
  logic [3:0]  ena, ena2, hrdy;
  logic [31:0] meth, v, meth2, v2;
  logic [15:0] dc;
  logic [1:0]  dc2;
  logic [2:0]  occ, occ2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  indication_input_demux dut (
    .CLK                   (CLK),
    .nRST                  (nRST),
    .pipe_enq_vld          (enq_ena),
    .pipe_enq_dat          (enq_v),
    .pipe_enq_rdy          (rdy),
    .indication_heard_vld  (ena),
    .indication_heard_meth (meth),
    .indication_heard_v    (v),
    .indication_heard_rdy  (hrdy),
    .drop_count            (dc),
    .occupancy             (occ)
  );

  indication_input_demux #(.CNT_W(2)) dut2 (
    .CLK                   (CLK),
    .nRST                  (nRST),
    .pipe_enq_vld          (enq_ena2),
    .pipe_enq_dat          (enq_v2),
    .pipe_enq_rdy          (rdy2),
    .indication_heard_vld  (ena2),
    .indication_heard_meth (meth2),
    .indication_heard_v    (v2),
    .indication_heard_rdy  (4'hF),
    .drop_count            (dc2),
    .occupancy             (occ2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of accepted messages plus a drop tally.
  typedef struct {
    int          ch;
    logic [31:0] meth;
    logic [31:0] v;
  } ent_t;

  ent_t q[$];
  int   m_drops  = 0;
  bit   m_rdy_en = 0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q.delete();
      m_drops  = 0;
      m_rdy_en = 0;
    end else begin
      bit          can_enq;
      logic [31:0] t;
      can_enq = m_rdy_en && (q.size() < 4);
      if (q.size() > 0 && hrdy[q[0].ch]) void'(q.pop_front());
      if (enq_ena && can_enq) begin
        t = enq_v[31:0];
        if (t >= 1 && t < 5) q.push_back('{ch: int'(t) - 1, meth: enq_v[63:32], v: enq_v[95:64]});
        else if (m_drops < 65535) m_drops++;
      end
      m_rdy_en = 1;
    end
  end

  always @(negedge CLK) begin
    logic [3:0]  e_ena;
    logic [31:0] e_meth, e_v;
    e_ena  = (q.size() != 0) ? (4'b0001 << q[0].ch) : 4'b0000;
    e_meth = (q.size() != 0) ? q[0].meth : 32'd0;
    e_v    = (q.size() != 0) ? q[0].v : 32'd0;
    check("model_rdy",  rdy,  (m_rdy_en && q.size() < 4) ? 1 : 0);
    check("model_ena",  ena,  e_ena);
    check("model_meth", meth, e_meth);
    check("model_v",    v,    e_v);
    check("model_occ",  occ,  q.size());
    check("model_drop", dc,   m_drops);
  end

  task automatic put(input logic [31:0] tag, input logic [31:0] m, input logic [31:0] vv);
    enq_ena = 1'b1;
    enq_v   = {vv, m, tag};
  endtask

  task automatic put2(input logic [31:0] tag);
    enq_ena2 = 1'b1;
    enq_v2   = {32'h0, 32'h0, tag};
  endtask

  initial begin
    logic [31:0] bad_tags [5];
    nRST = 1'b0; enq_ena = 1'b0; enq_v = '0; hrdy = 4'h0; enq_ena2 = 1'b0; enq_v2 = '0;
    bad_tags[0] = 32'd0; bad_tags[1] = 32'd5; bad_tags[2] = 32'd9;
    bad_tags[3] = 32'd100; bad_tags[4] = 32'hFFFF_FFFF;

    @(negedge CLK);
    check("rst_rdy", rdy, 0);
    check("rst_ena", ena, 0);
    check("rst_occ", occ, 0);
    check("rst_meth", meth, 0);
    #2 nRST = 1'b1;
    @(negedge CLK);
    check("rdy_after_release", rdy, 1);

    // single word to channel 0
    #1 put(1, 5, 32'h1234); hrdy = 4'b0001;
    @(negedge CLK);
    check("t1_ena", ena, 4'b0001);
    check("t1_meth", meth, 5);
    check("t1_v", v, 32'h1234);
    check("t1_occ", occ, 1);
    #1 enq_ena = 1'b0;
    @(negedge CLK);
    check("t1_occ_after", occ, 0);

    // fill to full, ignored fifth, ordered drain
    #1 hrdy = 4'h0; put(2, 20, 200);
    @(negedge CLK); #1 put(3, 30, 300);
    @(negedge CLK); #1 put(4, 40, 400);
    @(negedge CLK); #1 put(1, 10, 100);
    @(negedge CLK);
    check("t2_rdy_full", rdy, 0);
    check("t2_occ_full", occ, 4);
    check("t2_ena0", ena, 4'b0010);
    #1 put(2, 99, 999);
    @(negedge CLK);
    check("t2_occ_hold", occ, 4);
    check("t2_meth_head", meth, 20);
    #1 enq_ena = 1'b0; hrdy = 4'hF;
    @(negedge CLK); check("t2_ena1", ena, 4'b0100);
    @(negedge CLK); check("t2_ena2", ena, 4'b1000);
    @(negedge CLK); check("t2_ena3", ena, 4'b0001);
    @(negedge CLK); check("t2_empty", occ, 0);

    // unknown tags
    #1 put(0, 1, 1);
    @(negedge CLK); #1 put(9, 2, 2);
    @(negedge CLK);
    check("t3_drops", dc, 2);
    check("t3_occ", occ, 0);
    check("t3_ena", ena, 0);
    #1 enq_ena = 1'b0;

    // head-of-line blocking
    #1 hrdy = 4'b0100; put(2, 21, 0);
    @(negedge CLK); #1 put(3, 31, 0);
    @(negedge CLK); #1 enq_ena = 1'b0;
    @(negedge CLK);
    check("t4_ena_block", ena, 4'b0010);
    check("t4_occ", occ, 2);
    #1 hrdy = 4'b0110;
    @(negedge CLK); check("t4_ena_second", ena, 4'b0100);
    check("t4_meth_second", meth, 31);
    @(negedge CLK); check("t4_occ_done", occ, 0);

    // full with concurrent dequeue and enqueue attempt
    #1 hrdy = 4'h0; put(1, 1, 1);
    repeat (3) begin @(negedge CLK); #1 put(1, 1, 1); end
    @(negedge CLK);
    check("t5_full", occ, 4);
    #1 hrdy = 4'b0001; put(2, 7, 7);
    @(negedge CLK);
    check("t5_occ3", occ, 3);
    check("t5_rdy", rdy, 1);
    #1 enq_ena = 1'b0; hrdy = 4'h0;
    @(negedge CLK); check("t5_occ_stay", occ, 3);
    #1 hrdy = 4'hF;
    repeat (3) @(negedge CLK);
    check("t5_drained", occ, 0);

    // asynchronous reset with entries buffered
    #1 hrdy = 4'h0; put(1, 1, 1);
    @(negedge CLK); #1 put(2, 2, 2);
    @(negedge CLK); #1 put(3, 3, 3);
    @(negedge CLK); #1 enq_ena = 1'b0;
    check("t6_occ3", occ, 3);
    #2 nRST = 1'b0;
    #1 check("t6_ena_rst", ena, 0);
    check("t6_occ_rst", occ, 0);
    @(negedge CLK); #2 nRST = 1'b1;
    @(negedge CLK);
    check("t6_occ_after", occ, 0);
    check("t6_drop_after", dc, 0);

    // saturating narrow counter
    #1 hrdy = 4'hF;
    for (int i = 0; i < 5; i++) begin
      #1 put2(bad_tags[i]);
      @(negedge CLK);
      if (i == 1) check("t7_dc2_two", dc2, 2);
      if (i == 2) check("t7_dc2_three", dc2, 3);
    end
    check("t7_dc2_sat", dc2, 3);
    check("t7_ena2", ena2, 0);
    check("t7_occ2", occ2, 0);
    check("t7_meth2_v2", {meth2, v2}, 0);
    check("t7_rdy2", rdy2, 1);
    #1 enq_ena2 = 1'b0;

    // randomized traffic, one asynchronous reset in the middle
    for (int c = 0; c < 3000; c++) begin
      #1;
      enq_ena = ($urandom_range(0, 1) == 1);
      begin
        logic [31:0] t;
        int          r;
        r = $urandom_range(0, 9);
        if (r < 7)       t = $urandom_range(1, 4);
        else if (r == 7) t = 0;
        else if (r == 8) t = $urandom_range(5, 20);
        else             t = $urandom;
        enq_v = {32'($urandom), 32'($urandom), t};
      end
      hrdy = 4'($urandom);
      if (c == 1500) begin
        #2 nRST = 1'b0;
        #4 nRST = 1'b1;
      end
      @(negedge CLK);
    end
    #1 enq_ena = 1'b0; hrdy = 4'hF;
    repeat (6) @(negedge CLK);
    check("final_empty", occ, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/indication_input_demux.md
Name: indication_input_demux

Overview:
- Parametrised successor to the single-entry, single-method indication input stage.
- Accepts tagged request words from the portal pipe and buffers them in a DEPTH-entry FIFO.
- Dispatches each word to one of NUM_CH indication channels, selected by tag.
- Words with unknown tags are dropped and counted, so the pipe never stalls on a bad message.

Parameters:
- DATA_W, 32, width of the meth and v fields.
- TAG_W, 32, width of the tag field.
- NUM_CH, 4, number of indication channels (1..16).
- TAG_BASE, 1, tag value that maps to channel 0. Channel i is selected by tag TAG_BASE+i.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the drop counter.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- pipe$enq__ENA  in  1  enqueue strobe.
- pipe$enq$v  in  TAG_W+2*DATA_W  message: tag [TAG_W-1:0], meth next DATA_W bits, v top DATA_W bits.
- pipe$enq__RDY  out  1  FIFO not full.
- indication$heard__ENA  out  NUM_CH  one-hot request to the head entry's channel.
- indication$heard$meth  out  DATA_W  head entry meth.
- indication$heard$v  out  DATA_W  head entry v.
- indication$heard__RDY  in  NUM_CH  per-channel accept.
- drop_count  out  CNT_W  number of unknown-tag messages, saturating.
- occupancy  out  $clog2(DEPTH)+1  current FIFO entry count.

Behaviour:
- Reset (nRST low, asynchronous) clears pointers, occupancy, drop_count and all stored entries.
  - While in reset: pipe$enq__RDY=0, heard__ENA=0, meth=0, v=0.
  - pipe$enq__RDY rises the first cycle after reset release.
  - Reset mid-transfer discards every buffered entry with no dispatch.
- Enqueue handshake:
  - pipe$enq__RDY = occupancy != DEPTH.
  - An enqueue fires when ENA & RDY. ENA while RDY=0 is ignored; the sender must hold.
- Tag decode at enqueue:
  - ch = tag - TAG_BASE, computed at TAG_W width.
  - Valid when TAG_BASE <= tag < TAG_BASE+NUM_CH.
  - Valid: store {ch, meth, v} at the write pointer.
  - Invalid: store nothing and increment drop_count, saturating at 2^CNT_W-1.
  - A dropped message still consumes the handshake.
- Dispatch:
  - When the FIFO is non-empty, heard__ENA[head.ch]=1 and all other bits are 0.
  - meth and v show the head entry. Both are 0 when the FIFO is empty.
  - Dequeue fires when heard__ENA[head.ch] & heard__RDY[head.ch]. The read pointer advances on that edge.
  - ENA does not depend on RDY.
  - Strict in-order, head-of-line blocking: a stalled channel blocks all others.
- Latency: a word enqueued at edge N is first presented at the output in the cycle after edge N. There is no bypass path.
- Simultaneous enqueue and dequeue in one cycle:
  - Occupancy is unchanged.
  - This is legal at any occupancy below DEPTH.
  - When full, RDY=0, so no enqueue occurs even if a dequeue fires that cycle.
- Dropped enqueue together with a dequeue: occupancy decrements by 1.
- Pointers are log2(DEPTH)+1 bits with wrap bit. Full = MSBs differ and LSBs equal. Empty = pointers equal.
- Simulation-only: $display on each drop, printing the tag.

Decomposition:
- Shared package indication_pkg holds:
  - field offsets (TAG_LO, METH_LO, V_LO);
  - channel-index width CH_W = $clog2(NUM_CH) (minimum 1);
  - a function tag_to_ch returning {valid, ch}.
- Sub-module indication_fifo: generic synchronous FIFO of width CH_W+2*DATA_W with enq/deq/full/empty/count ports, reused elsewhere.
- The top level owns decode, the drop counter and one-hot dispatch.

Test Plan:
- Reset release, then enqueue tag=1 meth=5 v=0x1234 with RDY[0]=1 → next cycle ENA=4'b0001, meth=5, v=0x1234. Dequeues that edge; occupancy returns to 0.
- Enqueue tags 2,3,4,1 back-to-back with all RDY=0 → after 4 enqueues pipe$enq__RDY=0 and occupancy=4. A 5th ENA is ignored. Raising all RDY yields ENA 0010, 0100, 1000, 0001 on consecutive cycles.
- Enqueue tag=0, then tag=9 (NUM_CH=4, TAG_BASE=1) → drop_count=2, occupancy=0, ENA never asserts.
- Head tag=2 with RDY[1]=0, second entry tag=3 with RDY[2]=1 → ENA stays 0010 and the second entry is not presented. Raising RDY[1] releases both in order.
- Full FIFO, dequeue the head and assert pipe$enq__ENA in the same cycle → no enqueue (RDY=0). Occupancy goes 4→3, and RDY=1 the next cycle.
- Assert nRST low asynchronously with 3 entries buffered → ENA=0 and occupancy=0 immediately. After release the FIFO is empty and drop_count=0.
- CNT_W=2 override, 5 bad tags → drop_count saturates at 3.
